// File: rtl/tt_sched_pkg.sv
// Shared types and encodings for the 1 ms frontend timer scheduler.
package tt_sched_pkg;

    localparam int unsigned DEF_PERIOD_W = 48;

    typedef enum logic [1:0] {
        HALT = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam logic [1:0] CMD_NOP     = 2'd0;
    localparam logic [1:0] CMD_HALT    = 2'd1;
    localparam logic [1:0] CMD_ARM     = 2'd2;
    localparam logic [1:0] CMD_CLR_ERR = 2'd3;

endpackage

// File: rtl/tt_slot.sv
// One-entry valid/ready output register for time-tags; busy flags a stalled, occupied slot.
// Optional tt parity output when TT_PARITY_EN is defined.
module tt_slot #(
    parameter int unsigned W = 48
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] data,
`ifdef TT_PARITY_EN
    output logic         parity,
`endif
    output logic         busy
);

    assign busy = valid & ~ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid  <= 1'b0;
            data   <= '0;
`ifdef TT_PARITY_EN
            parity <= 1'b0;
`endif
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load && !busy) begin
            valid  <= 1'b1;
            data   <= load_data;
`ifdef TT_PARITY_EN
            parity <= ^load_data;
`endif
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/tt_sched.sv
// Timer controller: arms on a sync edge, emits period+offset time-tags, counts dropped tags.
// Optional tt_parity output when TT_PARITY_EN is defined.
module tt_sched
    import tt_sched_pkg::*;
#(
    parameter int unsigned PERIOD_W     = DEF_PERIOD_W,
    parameter int unsigned MISS_W       = 8,
    parameter int unsigned SYNC_TIMEOUT = 200000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [PERIOD_W-1:0] cmd_data,
    input  logic                sync_in,
    output logic                timer_rst,
    input  logic [PERIOD_W-1:0] period,
    input  logic                period_done,
    output logic                tt_valid,
    input  logic                tt_ready,
    output logic [PERIOD_W-1:0] tt_data,
`ifdef TT_PARITY_EN
    output logic                tt_parity,
`endif
    output logic                running,
    output logic [MISS_W-1:0]   miss_cnt,
    output logic                sync_err
);

    localparam int unsigned TO_W = $clog2(SYNC_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(SYNC_TIMEOUT - 1);

    state_t              state;
    logic [PERIOD_W-1:0] offset;
    logic                sync_prev;
    logic [TO_W-1:0]     to_cnt;

    logic cmd_fire, is_halt, is_arm, is_clr, sync_edge;
    logic slot_flush, slot_load, slot_busy;
    logic [PERIOD_W-1:0] tag_next;

    assign cmd_fire  = cmd_valid & cmd_ready;
    assign is_halt   = cmd_fire && (cmd_op == CMD_HALT);
    assign is_arm    = cmd_fire && (cmd_op == CMD_ARM);
    assign is_clr    = cmd_fire && (cmd_op == CMD_CLR_ERR);
    assign sync_edge = sync_in & ~sync_prev;

    // Leaving RUN discards any pending tag and beats a coincident period_done.
    assign slot_flush = (state == RUN) & (is_halt | is_arm);
    assign slot_load  = (state == RUN) & period_done & ~is_halt & ~is_arm;
    assign tag_next   = period + offset;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HALT;
            timer_rst <= 1'b1;
            running   <= 1'b0;
            cmd_ready <= 1'b1;
            offset    <= '0;
            sync_prev <= 1'b0;
            to_cnt    <= '0;
            sync_err  <= 1'b0;
        end else begin
            cmd_ready <= 1'b1;
            sync_prev <= sync_in;
            case (state)
                HALT: begin
                    if (is_arm) begin
                        state  <= ARM;
                        offset <= cmd_data;
                        to_cnt <= '0;
                    end
                end
                ARM: begin
                    if (is_halt) begin
                        state <= HALT;
                    end else if (is_arm) begin
                        offset <= cmd_data;
                        to_cnt <= '0;
                    end else if (sync_edge) begin
                        state     <= RUN;
                        timer_rst <= 1'b0;
                        running   <= 1'b1;
                    end else if (to_cnt == TO_LAST) begin
                        state    <= HALT;
                        sync_err <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                RUN: begin
                    if (is_halt || is_arm) begin
                        state     <= is_arm ? ARM : HALT;
                        timer_rst <= 1'b1;
                        running   <= 1'b0;
                        if (is_arm) begin
                            offset <= cmd_data;
                            to_cnt <= '0;
                        end
                    end
                end
                default: begin
                    state     <= HALT;
                    timer_rst <= 1'b1;
                    running   <= 1'b0;
                end
            endcase
            if (is_clr) begin
                sync_err <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss_cnt <= '0;
        end else if (is_clr) begin
            miss_cnt <= '0;
        end else if (slot_load && slot_busy && (miss_cnt != {MISS_W{1'b1}})) begin
            miss_cnt <= miss_cnt + MISS_W'(1);
        end
    end

    tt_slot #(
        .W(PERIOD_W)
    ) u_slot (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (slot_flush),
        .load     (slot_load),
        .load_data(tag_next),
        .ready    (tt_ready),
        .valid    (tt_valid),
        .data     (tt_data),
`ifdef TT_PARITY_EN
        .parity   (tt_parity),
`endif
        .busy     (slot_busy)
    );

endmodule

// File: tb/tb_tt_sched.sv
// Directed-vector bench for tt_sched (SYNC_TIMEOUT shortened to 100).
module tb_tt_sched;

    localparam int unsigned PW = 48;
    localparam int unsigned MW = 8;
    localparam int OP_NOP = 0, OP_HALT = 1, OP_ARM = 2, OP_CLR = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'd0;
    logic [PW-1:0] cmd_data = '0;
    logic          sync_in = 1'b0;
    logic          timer_rst;
    logic [PW-1:0] period = '0;
    logic          period_done = 1'b0;
    logic          tt_valid;
    logic          tt_ready = 1'b1;
    logic [PW-1:0] tt_data;
    logic          running;
    logic [MW-1:0] miss_cnt;
    logic          sync_err;
`ifdef TT_PARITY_EN
    logic          tt_parity;
`endif

    always #5 clk = ~clk;

    tt_sched #(
        .PERIOD_W    (PW),
        .MISS_W      (MW),
        .SYNC_TIMEOUT(100)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .sync_in    (sync_in),
        .timer_rst  (timer_rst),
        .period     (period),
        .period_done(period_done),
        .tt_valid   (tt_valid),
        .tt_ready   (tt_ready),
        .tt_data    (tt_data),
`ifdef TT_PARITY_EN
        .tt_parity  (tt_parity),
`endif
        .running    (running),
        .miss_cnt   (miss_cnt),
        .sync_err   (sync_err)
    );

    typedef struct {
        logic          cv;
        logic [1:0]    op;
        logic [PW-1:0] data;
        logic          sync;
        logic [PW-1:0] per;
        logic          pd;
        logic          rdy;
        int            rep;
        logic          trst;
        logic          run;
        logic          tv;
        logic [PW-1:0] td;
        logic [MW-1:0] miss;
        logic          serr;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    function automatic vec_t mk(int cv, int op, longint unsigned data, int s,
                                longint unsigned per, int pd, int rdy, int rep,
                                int trst, int run, int tv, longint unsigned td,
                                int miss, int serr);
        vec_t v;
        v.cv   = cv[0];
        v.op   = op[1:0];
        v.data = data[PW-1:0];
        v.sync = s[0];
        v.per  = per[PW-1:0];
        v.pd   = pd[0];
        v.rdy  = rdy[0];
        v.rep  = rep;
        v.trst = trst[0];
        v.run  = run[0];
        v.tv   = tv[0];
        v.td   = td[PW-1:0];
        v.miss = miss[MW-1:0];
        v.serr = serr[0];
        return v;
    endfunction

    task automatic check(string name, logic [63:0] got, logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic check_all(string tag, logic trst, logic run, logic tv, logic [PW-1:0] td,
                             logic [MW-1:0] miss, logic serr);
        check({tag, " cmd_ready"}, 64'(cmd_ready), 64'(1'b1));
        check({tag, " timer_rst"}, 64'(timer_rst), 64'(trst));
        check({tag, " running"},   64'(running),   64'(run));
        check({tag, " tt_valid"},  64'(tt_valid),  64'(tv));
        check({tag, " tt_data"},   64'(tt_data),   64'(td));
        check({tag, " miss_cnt"},  64'(miss_cnt),  64'(miss));
        check({tag, " sync_err"},  64'(sync_err),  64'(serr));
`ifdef TT_PARITY_EN
        check({tag, " tt_parity"}, 64'(tt_parity), 64'(^td));
`endif
    endtask

    initial begin
        //            cv op       data            s  per     pd rdy rep  trst run tv td     miss serr
        vecs.push_back(mk(1, OP_ARM,  64'h10, 0, 0,     0, 1, 1,   1, 0, 0, 0,      0,   0));
        vecs.push_back(mk(0, OP_NOP,  0,      0, 0,     0, 1, 4,   1, 0, 0, 0,      0,   0));
        vecs.push_back(mk(0, OP_NOP,  0,      1, 0,     0, 1, 1,   0, 1, 0, 0,      0,   0));
        vecs.push_back(mk(0, OP_NOP,  0,      1, 7,     1, 1, 1,   0, 1, 1, 64'h17, 0,   0));
        vecs.push_back(mk(0, OP_NOP,  0,      1, 7,     0, 1, 1,   0, 1, 0, 64'h17, 0,   0));
        vecs.push_back(mk(1, OP_ARM,  0,      1, 0,     0, 1, 1,   1, 0, 0, 64'h17, 0,   0));
        vecs.push_back(mk(0, OP_NOP,  0,      0, 0,     0, 1, 1,   1, 0, 0, 64'h17, 0,   0));
        vecs.push_back(mk(0, OP_NOP,  0,      1, 0,     0, 1, 1,   0, 1, 0, 64'h17, 0,   0));
        vecs.push_back(mk(0, OP_NOP,  0,      1, 1,     1, 0, 1,   0, 1, 1, 1,      0,   0));
        vecs.push_back(mk(0, OP_NOP,  0,      1, 1,     0, 0, 1,   0, 1, 1, 1,      0,   0));
        vecs.push_back(mk(0, OP_NOP,  0,      1, 2,     1, 0, 1,   0, 1, 1, 1,      1,   0));
        vecs.push_back(mk(0, OP_NOP,  0,      1, 3,     1, 0, 1,   0, 1, 1, 1,      2,   0));
        vecs.push_back(mk(0, OP_NOP,  0,      1, 4,     1, 0, 1,   0, 1, 1, 1,      3,   0));
        vecs.push_back(mk(1, OP_CLR,  0,      1, 5,     1, 0, 1,   0, 1, 1, 1,      0,   0));
        vecs.push_back(mk(0, OP_NOP,  0,      1, 5,     0, 1, 1,   0, 1, 0, 1,      0,   0));
        vecs.push_back(mk(0, OP_NOP,  0,      1, 9,     1, 0, 1,   0, 1, 1, 9,      0,   0));
        vecs.push_back(mk(0, OP_NOP,  0,      1, 10,    1, 1, 1,   0, 1, 1, 10,     0,   0));
        vecs.push_back(mk(0, OP_NOP,  0,      1, 10,    0, 1, 1,   0, 1, 0, 10,     0,   0));
        vecs.push_back(mk(1, OP_HALT, 0,      1, 11,    1, 1, 1,   1, 0, 0, 10,     0,   0));
        vecs.push_back(mk(1, OP_ARM,  64'hFFFF_FFFF_FFFF, 1, 0, 0, 1, 1, 1, 0, 0, 10, 0, 0));
        vecs.push_back(mk(0, OP_NOP,  0,      0, 0,     0, 1, 1,   1, 0, 0, 10,     0,   0));
        vecs.push_back(mk(0, OP_NOP,  0,      1, 0,     0, 1, 1,   0, 1, 0, 10,     0,   0));
        vecs.push_back(mk(0, OP_NOP,  0,      1, 5,     1, 1, 1,   0, 1, 1, 4,      0,   0));
        vecs.push_back(mk(0, OP_NOP,  0,      1, 5,     0, 1, 1,   0, 1, 0, 4,      0,   0));
        vecs.push_back(mk(0, OP_NOP,  0,      1, 5,     1, 0, 300, 0, 1, 1, 4,      255, 0));
        vecs.push_back(mk(1, OP_ARM,  0,      1, 5,     1, 0, 1,   1, 0, 0, 4,      255, 0));
        vecs.push_back(mk(1, OP_CLR,  0,      1, 5,     1, 0, 1,   1, 0, 0, 4,      0,   0));
        vecs.push_back(mk(0, OP_NOP,  0,      1, 5,     1, 0, 98,  1, 0, 0, 4,      0,   0));
        vecs.push_back(mk(0, OP_NOP,  0,      1, 5,     1, 0, 1,   1, 0, 0, 4,      0,   1));
        vecs.push_back(mk(0, OP_NOP,  0,      1, 5,     1, 0, 3,   1, 0, 0, 4,      0,   1));
        vecs.push_back(mk(1, OP_CLR,  0,      0, 0,     0, 1, 1,   1, 0, 0, 4,      0,   0));
        vecs.push_back(mk(1, OP_ARM,  64'h100, 1, 0,    0, 1, 1,   1, 0, 0, 4,      0,   0));
        vecs.push_back(mk(0, OP_NOP,  0,      1, 0,     0, 1, 1,   1, 0, 0, 4,      0,   0));
        vecs.push_back(mk(0, OP_NOP,  0,      0, 0,     0, 1, 1,   1, 0, 0, 4,      0,   0));
        vecs.push_back(mk(0, OP_NOP,  0,      1, 0,     0, 1, 1,   0, 1, 0, 4,      0,   0));
        vecs.push_back(mk(0, OP_NOP,  0,      1, 64'h20, 1, 0, 1,  0, 1, 1, 64'h120, 0,  0));

        #12;
        check_all("reset", 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            for (int r = 0; r < vecs[i].rep; r++) begin
                cmd_valid   = vecs[i].cv;
                cmd_op      = vecs[i].op;
                cmd_data    = vecs[i].data;
                sync_in     = vecs[i].sync;
                period      = vecs[i].per;
                period_done = vecs[i].pd;
                tt_ready    = vecs[i].rdy;
                @(posedge clk);
                #1;
            end
            check_all($sformatf("v%0d", i), vecs[i].trst, vecs[i].run, vecs[i].tv, vecs[i].td,
                      vecs[i].miss, vecs[i].serr);
        end

        // Asynchronous reset mid-RUN with a tag pending and period_done still pulsing.
        cmd_valid   = 1'b0;
        period_done = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        @(posedge clk);
        #1;
        check_all("held_rst", 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        period_done = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("post_rst", 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
